// File: rtl/rgb565_frame_fifo.sv
// rgb565_frame_fifo
// Elastic buffer between pixel conversion and the output-buffer write side.
// Each stored entry carries the pixel plus raster tags {eof, eol, sof}.
//
// Handshake: the output side is first-word-fall-through. wOValid is high
// whenever at least one entry is held; a pixel leaves the FIFO on every
// iClk cycle where wOValid and wOReady are both high. While wOValid=1 and
// wOReady=0 the head entry (data and tags) is held stable. The input side
// has no backpressure: a push attempt into a full FIFO without a same-cycle
// pop drops the pixel and sets the sticky overflow flag.
module rgb565_frame_fifo #(
    parameter int H_ACT = 480,
    parameter int V_ACT = 272,
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic                     iClk,
    input  logic                     wRst,
    input  logic                     wEnClk,
    input  logic                     wStCnn,
    input  logic                     wFgRgb565Valid,
    input  logic [DW-1:0]            wRgb565,
    input  logic                     wOReady,
    output logic                     wOValid,
    output logic [DW-1:0]            wOData,
    output logic                     wOSof,
    output logic                     wOEol,
    output logic                     wOEof,
    output logic                     wOvf,
    output logic [$clog2(DEPTH):0]   wLevel,
    output logic                     wFrameDone
);

    localparam int AW = $clog2(DEPTH);
    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);
    localparam int EW = DW + 3;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACT - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACT - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);

    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ovf_q, ovf_d;
    logic          fdone_q, fdone_d;

    logic          push_try;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          sof_tag, eol_tag, eof_tag;
    logic [EW-1:0] head;
    logic [EW-1:0] wr_entry;

    // Push/pop decisions, raster tagging and next-state for all control registers.
    always_comb begin
        push_try = wEnClk & wFgRgb565Valid & wStCnn;
        full     = (level_q == FULL_LVL);
        pop      = (level_q != '0) & wOReady;
        // A full FIFO can still accept when the head leaves in the same cycle.
        push_ok  = push_try & (~full | pop);
        head     = mem_q[rd_ptr_q];

        sof_tag  = (x_q == '0) && (y_q == '0);
        eol_tag  = (x_q == X_LAST);
        eof_tag  = eol_tag && (y_q == Y_LAST);
        wr_entry = {eof_tag, eol_tag, sof_tag, wRgb565};

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Position advances on every attempt (stored or dropped) so tags stay
        // raster-aligned; an idle CNN parks the position at the frame origin.
        x_d = x_q;
        y_d = y_q;
        if (!wStCnn) begin
            x_d = '0;
            y_d = '0;
        end else if (push_try) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + Y_ONE;
            end else begin
                x_d = x_q + X_ONE;
            end
        end

        ovf_d   = ovf_q | (push_try & ~push_ok);
        fdone_d = pop & head[EW-1];
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge iClk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge iClk) begin
        if (wRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            fdone_q  <= fdone_d;
        end
    end

    // Head data and tags are gated by valid so every output reads 0 when empty.
    always_comb begin
        wOValid    = (level_q != '0);
        wOData     = wOValid ? head[DW-1:0] : '0;
        wOSof      = wOValid & head[DW];
        wOEol      = wOValid & head[DW+1];
        wOEof      = wOValid & head[DW+2];
        wOvf       = ovf_q;
        wLevel     = level_q;
        wFrameDone = fdone_q;
    end

endmodule

// File: tb/tb_rgb565_frame_fifo.sv
// Bench for rgb565_frame_fifo using a 4x2 frame and a 16-entry FIFO.
module tb_rgb565_frame_fifo;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int LW = $clog2(D) + 1;

    logic          clk;
    logic          wRst;
    logic          wEnClk;
    logic          wStCnn;
    logic          wFgRgb565Valid;
    logic [DW-1:0] wRgb565;
    logic          wOReady;
    logic          wOValid;
    logic [DW-1:0] wOData;
    logic          wOSof;
    logic          wOEol;
    logic          wOEof;
    logic          wOvf;
    logic [LW-1:0] wLevel;
    logic          wFrameDone;

    rgb565_frame_fifo #(
        .H_ACT(H),
        .V_ACT(V),
        .DEPTH(D),
        .DW(DW)
    ) dut (
        .iClk(clk),
        .wRst(wRst),
        .wEnClk(wEnClk),
        .wStCnn(wStCnn),
        .wFgRgb565Valid(wFgRgb565Valid),
        .wRgb565(wRgb565),
        .wOReady(wOReady),
        .wOValid(wOValid),
        .wOData(wOData),
        .wOSof(wOSof),
        .wOEol(wOEol),
        .wOEof(wOEof),
        .wOvf(wOvf),
        .wLevel(wLevel),
        .wFrameDone(wFrameDone)
    );

    // Clock and initial input levels
    initial begin
        clk            = 1'b0;
        wRst           = 1'b1;
        wEnClk         = 1'b0;
        wStCnn         = 1'b0;
        wFgRgb565Valid = 1'b0;
        wRgb565        = '0;
        wOReady        = 1'b0;
    end
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard / reference state: expected entries are {eof, eol, sof, data}
    logic [DW+2:0] exp_q[$];
    int            mdl_level;
    int            mdl_x;
    int            mdl_y;
    logic          mdl_ovf;

    task automatic model_clear();
        exp_q.delete();
        mdl_level = 0;
        mdl_x     = 0;
        mdl_y     = 0;
        mdl_ovf   = 1'b0;
    endtask

    // One-cycle reset pulse; every output must read 0 afterwards.
    task automatic do_reset();
        @(negedge clk);
        wRst           = 1'b1;
        wStCnn         = 1'b0;
        wEnClk         = 1'b0;
        wFgRgb565Valid = 1'b0;
        wRgb565        = '0;
        wOReady        = 1'b0;
        @(posedge clk);
        #1;
        wRst = 1'b0;
        check("rst_valid", 32'(wOValid), 32'(0));
        check("rst_data",  32'(wOData), 32'(0));
        check("rst_tags",  32'({wOEof, wOEol, wOSof}), 32'(0));
        check("rst_level", 32'(wLevel), 32'(0));
        check("rst_ovf",   32'(wOvf), 32'(0));
        check("rst_fdone", 32'(wFrameDone), 32'(0));
        model_clear();
    endtask

    // Drive one cycle, check head against the scoreboard, then check level/ovf/frame-done.
    task automatic step(input logic st, input logic en, input logic vld,
                        input logic [DW-1:0] d, input logic rdy);
        logic          pop_now;
        logic          exp_fd;
        logic [DW+2:0] hd;
        logic          sof, eol, eof;
        hd = '0;
        @(negedge clk);
        wStCnn         = st;
        wEnClk         = en;
        wFgRgb565Valid = vld;
        wRgb565        = d;
        wOReady        = rdy;
        check("valid", 32'(wOValid), 32'(mdl_level != 0));
        if (mdl_level != 0) begin
            hd = exp_q[0];
            check("head_data", 32'(wOData), 32'(hd[DW-1:0]));
            check("head_tags", 32'({wOEof, wOEol, wOSof}), 32'(hd[DW+2:DW]));
        end
        pop_now = rdy && (mdl_level != 0);
        exp_fd  = pop_now && hd[DW+2];
        if (pop_now) begin
            void'(exp_q.pop_front());
            mdl_level--;
        end
        if (st && en && vld) begin
            sof = (mdl_x == 0) && (mdl_y == 0);
            eol = (mdl_x == H - 1);
            eof = eol && (mdl_y == V - 1);
            if (mdl_level < D) begin
                exp_q.push_back({eof, eol, sof, d});
                mdl_level++;
            end else begin
                mdl_ovf = 1'b1;
            end
            if (mdl_x == H - 1) begin
                mdl_x = 0;
                mdl_y = (mdl_y == V - 1) ? 0 : mdl_y + 1;
            end else begin
                mdl_x++;
            end
        end
        if (!st) begin
            mdl_x = 0;
            mdl_y = 0;
        end
        @(posedge clk);
        #1;
        check("level", 32'(wLevel), 32'(mdl_level));
        check("ovf",   32'(wOvf), 32'(mdl_ovf));
        check("fdone", 32'(wFrameDone), 32'(exp_fd));
    endtask

    // Per-cycle vector table: inputs before the edge, expected outputs after it
    typedef struct {
        logic          rst;
        logic          st;
        logic          en;
        logic          vld;
        logic [DW-1:0] d;
        logic          rdy;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_sof;
        logic          e_eol;
        logic          e_eof;
        logic [LW-1:0] e_lvl;
        logic          e_ovf;
        logic          e_fd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic st, input logic en, input logic vld,
                       input logic [DW-1:0] d, input logic rdy, input logic e_valid,
                       input logic [DW-1:0] e_data, input logic e_sof, input logic e_eol,
                       input logic e_eof, input logic [LW-1:0] e_lvl, input logic e_ovf,
                       input logic e_fd);
        vec_t v;
        v.rst = rst; v.st = st; v.en = en; v.vld = vld; v.d = d; v.rdy = rdy;
        v.e_valid = e_valid; v.e_data = e_data; v.e_sof = e_sof; v.e_eol = e_eol;
        v.e_eof = e_eof; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_fd = e_fd;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset, single pixel F800, then drain
        add(1, 0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 16'hF800, 1,  1, 16'hF800, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 0, 0, 0, 0, 0);
        // Reset, then a full 4x2 frame streamed with ready held high
        add(1, 0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 16'h0000, 1,  1, 16'h0000, 1, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0001, 1,  1, 16'h0001, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0002, 1,  1, 16'h0002, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0003, 1,  1, 16'h0003, 0, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0004, 1,  1, 16'h0004, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0005, 1,  1, 16'h0005, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0006, 1,  1, 16'h0006, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0007, 1,  1, 16'h0007, 0, 1, 1, 1, 0, 0);
        // Pixel 7 pops here: frame-done pulses, pixel 8 starts a new frame
        add(0, 1, 1, 1, 16'h0008, 1,  1, 16'h0008, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wRst           = vecs[i].rst;
            wStCnn         = vecs[i].st;
            wEnClk         = vecs[i].en;
            wFgRgb565Valid = vecs[i].vld;
            wRgb565        = vecs[i].d;
            wOReady        = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(wOValid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_data", i),  32'(wOData), 32'(vecs[i].e_data));
            check($sformatf("vec%0d_sof", i),   32'(wOSof), 32'(vecs[i].e_sof));
            check($sformatf("vec%0d_eol", i),   32'(wOEol), 32'(vecs[i].e_eol));
            check($sformatf("vec%0d_eof", i),   32'(wOEof), 32'(vecs[i].e_eof));
            check($sformatf("vec%0d_level", i), 32'(wLevel), 32'(vecs[i].e_lvl));
            check($sformatf("vec%0d_ovf", i),   32'(wOvf), 32'(vecs[i].e_ovf));
            check($sformatf("vec%0d_fdone", i), 32'(wFrameDone), 32'(vecs[i].e_fd));
        end

        // Backpressure and overflow: 20 attempts into 16 entries
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1, 1, 16'(100 + i), 0);
        check("ovf_full_level", 32'(wLevel), 32'(16));
        check("ovf_flag", 32'(wOvf), 32'(1));
        check("ovf_head_held", 32'(wOData), 32'(100));
        for (int i = 0; i < 16; i++) step(1, 0, 0, 16'h0000, 1);
        // Position resumes at index 20 (x=0,y=1); index 23 closes the frame
        for (int i = 0; i < 4; i++) step(1, 1, 1, 16'(200 + i), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0000, 1);

        // Full FIFO with a simultaneous pop accepts the push
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 1, 1, 16'(500 + i), 0);
        step(1, 1, 1, 16'hAAAA, 1);
        check("fullpop_level", 32'(wLevel), 32'(16));
        check("fullpop_ovf", 32'(wOvf), 32'(0));
        for (int i = 0; i < 18; i++) step(1, 0, 0, 16'h0000, 1);

        // CNN drops mid-line: later pushes ignored, queue still drains
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 1, 16'(300 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 16'(400 + i), 0);
        check("idle_level", 32'(wLevel), 32'(5));
        step(1, 0, 1, 16'h0BAD, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 16'h0000, 1);
        step(1, 1, 1, 16'h0400, 1);
        check("restart_sof", 32'(wOSof), 32'(1));
        check("restart_data", 32'(wOData), 32'(16'h0400));
        for (int i = 0; i < 2; i++) step(1, 0, 0, 16'h0000, 1);

        // Reset while holding 10 entries with overflow set
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 1, 1, 16'(600 + i), 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0000, 1);
        check("midrst_pre_level", 32'(wLevel), 32'(10));
        check("midrst_pre_ovf", 32'(wOvf), 32'(1));
        do_reset();
        step(1, 1, 1, 16'h1234, 0);
        check("midrst_sof", 32'(wOSof), 32'(1));
        check("midrst_data", 32'(wOData), 32'(16'h1234));
        for (int i = 0; i < 2; i++) step(1, 0, 0, 16'h0000, 1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb565_frame_fifo.md
Name: rgb565_frame_fifo

Overview:
- Elastic buffer between PixelConversion (upstream) and the output-buffer write controller (downstream), in the 100 MHz processing domain.
- Accepts RGB565 pixels at the wEnClk pixel rate and tracks each pixel's raster position.
- Tags every pixel with start-of-frame, end-of-line and end-of-frame flags.
- Presents pixels to the consumer over a valid/ready handshake. Overflow is reported and never stalls the CNN pipeline.

Parameters:
- H_ACT, 480, active pixels per line
- V_ACT, 272, active lines per frame
- DEPTH, 16, FIFO entries (power of two, >= 4)
- DW, 16, pixel data width

Ports:
- iClk  in  1  100 MHz processing clock
- wRst  in  1  synchronous reset, active-high
- wEnClk  in  1  pixel-rate enable; input side samples only when high
- wStCnn  in  1  CNN-active state from MainFsm; low = idle
- wFgRgb565Valid  in  1  input pixel valid
- wRgb565  in  DW  input pixel
- wOReady  in  1  consumer ready
- wOValid  out  1  output pixel valid
- wOData  out  DW  output pixel
- wOSof  out  1  output pixel is x=0,y=0
- wOEol  out  1  output pixel is x=H_ACT-1
- wOEof  out  1  output pixel is x=H_ACT-1,y=V_ACT-1
- wOvf  out  1  sticky overflow flag
- wLevel  out  $clog2(DEPTH)+1  current occupancy
- wFrameDone  out  1  one-cycle pulse when the EOF pixel is popped

Behaviour:
- Reset (wRst=1 at a rising iClk edge):
  - Pointers, level, x/y counters and wOvf go to 0.
  - All outputs are 0 on the following cycle.
  - FIFO contents are don't-care.
  - Reset mid-frame discards all held pixels.
- Push attempt = wEnClk & wFgRgb565Valid & wStCnn.
- Storage entry = {eof, eol, sof, pixel}, DW+3 bits.
  - sof = (x==0 && y==0)
  - eol = (x==H_ACT-1)
  - eof = eol && (y==V_ACT-1)
- Position counters advance on every push attempt, whether stored or dropped, so tags stay raster-aligned.
  - x increments. At H_ACT-1, x wraps to 0 and y increments.
  - At the last pixel (x=H_ACT-1, y=V_ACT-1), x and y both wrap to 0.
- Pop = wOValid & wOReady, evaluated every iClk cycle, independent of wEnClk.
- Output is first-word-fall-through. wOValid = (level != 0). wOData and the tags reflect the head entry.
- Latency: a push into an empty FIFO gives wOValid=1 on the next cycle.
- Full with a push attempt:
  - If a pop occurs the same cycle, the push is accepted and level is unchanged.
  - Otherwise the pixel is dropped, wOvf sets, and the counters still advance.
- wOvf clears only on wRst.
- Empty with a pop is impossible because wOValid=0. Simultaneous push and pop when empty means the push is stored and level becomes 1.
- Level update: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- wOData must not change while wOValid=1 and wOReady=0.
- wFrameDone = registered (pop && head.eof): a 1-cycle pulse, one cycle after the pop.
- wStCnn low:
  - Input pushes are ignored and x/y are held at 0.
  - The FIFO continues draining, so queued pixels still reach the consumer.
  - Rising wStCnn therefore always starts a frame at x=0,y=0 with sof=1.
- Width rules:
  - x counter is $clog2(H_ACT) bits; y counter is $clog2(V_ACT) bits.
  - Compares are against parameter-1; no arithmetic overflow beyond the counter wrap.

Test Plan:
- Reset then single pixel: wStCnn=1, one push of 16'hF800 with wOReady=1 -> next cycle wOValid=1, wOData=F800, wOSof=1, wOEol=0; popped; wLevel returns to 0.
- Line/frame tagging: H_ACT=4, V_ACT=2, push 8 pixels 0..7 with ready=1 -> wOEol on pixels 3 and 7, wOEof only on 7, wFrameDone pulses once one cycle after pixel 7 pops; pixel 8 carries wOSof=1.
- Backpressure/overflow: DEPTH=16, wOReady=0, push 20 pixels 0..19 -> wLevel=16, wOvf=1, then wOReady=1 -> pops 0..15 in order; the next pushed pixel carries the position of index 20, e.g. x=20 with H_ACT=480.
- Full with simultaneous pop: fill to 16, hold wOReady=1 and push pixel AAAA the same cycle -> wLevel stays 16, wOvf stays 0, AAAA later emerges.
- wStCnn drop mid-line: push 5 pixels, drop wStCnn, push 3 more -> only the 5 appear, then restart -> first new pixel has wOSof=1.
- Reset mid-operation: FIFO holding 10 with wOvf=1, assert wRst one cycle -> wOValid=0, wLevel=0, wOvf=0, counters at 0.
